// File: rtl/onehot_checker_if.sv
// Stream bundle between a one-hot source and the checker: word in, encoded result out.
// Both directions use valid/ready handshakes.
interface onehot_checker_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_onehot;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_err;
    logic             out_seq_err;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_index, out_err, out_seq_err
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_index, out_err, out_seq_err
    );
endinterface

// File: rtl/onehot_checker.sv
// One-hot word checker: encodes to an index, flags non-one-hot and out-of-order words, tracks seen channels.
// One-cycle latency through a single output register; in_ready drops while a result is held unconsumed.
module onehot_checker #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    onehot_checker_if.slave  bus,
    output logic [WIDTH-1:0] seen_mask,
    output logic             all_seen,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [0:0] SCAN = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    logic [0:0]       state;
    logic [IDX_W-1:0] exp_idx;
    logic [IDX_W:0]   pop;
    logic [IDX_W-1:0] enc_idx;
    logic             is_onehot;
    logic             accept;

    always_comb begin
        pop     = '0;
        enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.in_onehot[i]) begin
                pop     = pop + (IDX_W+1)'(1);
                enc_idx = IDX_W'(i);
            end
        end
    end

    assign is_onehot    = (pop == (IDX_W+1)'(1));
    assign bus.in_ready = reset && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign all_seen     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_index   <= '0;
            bus.out_err     <= 1'b0;
            bus.out_seq_err <= 1'b0;
        end else if (accept) begin
            bus.out_valid   <= 1'b1;
            bus.out_index   <= is_onehot ? enc_idx : '0;
            bus.out_err     <= !is_onehot;
            bus.out_seq_err <= is_onehot && (enc_idx != exp_idx);
        end else if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
        end
    end

    // clear overrides any tracking effect of a word accepted on the same edge
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state     <= SCAN;
            seen_mask <= '0;
            err_count <= '0;
            exp_idx   <= '0;
        end else if (accept) begin
            if (is_onehot) begin
                exp_idx <= enc_idx + IDX_W'(1);
                if (state == SCAN) begin
                    seen_mask <= seen_mask | bus.in_onehot;
                    if ((seen_mask | bus.in_onehot) == '1)
                        state <= DONE;
                end
            end else if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end
endmodule

// File: doc/onehot_checker.md
# onehot_checker

Registered consumer for the 3-to-8 one-hot decoder output. It accepts 8-bit one-hot words over a valid/ready handshake and encodes each back to a 3-bit index. It flags words that are not one-hot and words that break the ascending 0..7 sweep order, and tracks which channels have been seen. It sits directly downstream of the decoder and closes the loop for self-checking decoder sweeps.

## Interface
- `WIDTH`, 8: one-hot input width.
- `IDX_W`, 3: index width; must equal log2(`WIDTH`).
- `ERR_W`, 8: width of the saturating error counter.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous soft clear of tracking state.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept input.
- `in_onehot`  in  `WIDTH`  word from the decoder.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_index`  out  `IDX_W`  encoded index.
- `out_err`  out  1  input word was not one-hot.
- `out_seq_err`  out  1  index differed from the expected index.
- `seen_mask`  out  `WIDTH`  channels seen since reset/clear.
- `all_seen`  out  1  every channel has been seen.
- `err_count`  out  `ERR_W`  saturating count of non-one-hot words.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = reset && (!out_valid || out_ready)`, so the single output register acts as a pass-through stage with backpressure.
- On accept, the output register loads and `out_valid` goes to 1:
  - Popcount == 1: `out_index` = bit position; `out_err` = 0; `out_seq_err` = (index != expected).
  - Expected index update after a popcount-1 word: index+1 mod 8. This also resyncs after a sequence error.
  - Popcount != 1 (including 0x00): `out_index` = 0; `out_err` = 1; `out_seq_err` = 0; expected index unchanged.
  - Popcount != 1 also increments `err_count`, which saturates at 2^`ERR_W`-1.
- Output handshake:
  - `out_valid` clears when `out_ready` is high and no new accept occurs in the same cycle.
  - Accept and drain in the same cycle: the register reloads and `out_valid` stays 1.
- FSM states SCAN and DONE:
  - SCAN: a valid one-hot word ORs into `seen_mask`.
  - SCAN -> DONE on the edge where `seen_mask` becomes all ones.
  - DONE: `seen_mask` is frozen. Words are still accepted, checked and counted.
  - DONE -> SCAN only on `clear` or `reset`.
- `all_seen = (state == DONE)`.
- `clear`:
  - Zeroes `seen_mask`, `err_count` and the expected index; returns the FSM to SCAN.
  - Does not touch the output register or `out_valid`.
  - `clear` with an accept in the same cycle: the word is still emitted, checked against the pre-clear expected index. Its mask, count and expected-index effects are discarded, because clear wins.
- `reset` low: all state returns to reset values and `in_ready` = 0. Any word in flight is dropped.

## Timing
- Reset values: `out_valid`=0, `out_index`=0, `out_err`=0, `out_seq_err`=0, `seen_mask`=0, `all_seen`=0, `err_count`=0, expected index = 0, FSM = SCAN.
- `in_ready` is 1 from the first cycle after `reset` is released.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 word per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`, all outputs hold stable and `in_ready` = 0.
- `seen_mask`, `err_count` and FSM update on the accept edge, so they are visible in the same cycle as the corresponding `out_valid`.
- Expected index wraps 7 -> 0 with no error.
- `err_count` stays at 255 (`ERR_W` = 8) at saturation.

## Test plan
- Sweep 0x01,0x02,…,0x80 back-to-back with `out_ready`=1:
  - `out_index` = 0..7 on consecutive cycles; `out_err`=`out_seq_err`=0.
  - `all_seen` rises with the 8th result; `seen_mask`=0xFF.
  - A 9th word 0x01 gives `out_seq_err`=0 (wrap).
- Inputs 0x00 then 0x03:
  - Both give `out_err`=1 and `out_index`=0.
  - `err_count`=2; `seen_mask` unchanged.
- Inputs 0x01, 0x04, 0x08:
  - `out_seq_err` = 0, 1, 0 (resync after 0x04).
  - `seen_mask`=0x0D.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 held on 0x02:
  - `in_ready`=0 and the output is held stable.
  - After release, each word appears exactly once: no loss, no duplication.
- 260 consecutive 0xFF words: `err_count` reaches 255 and stays.
- Protocol interruptions:
  - After DONE, `clear` together with an accept of 0x10: the result is emitted; `seen_mask`=0, `err_count`=0, FSM = SCAN.
  - `reset` low mid-stream: all outputs reach reset values on the next edge.
